psg_multi: RTL and testbench

Parametrised programmable sound generator: CHANNELS square-wave tone channels with TONE_W-bit periods, one shared 17-bit LFSR noise source and one shared 32-step envelope generator. It is the multi-channel successor to the 3-channel AY/YM PSG and sits between the CPU I/O decode and the audio mixer. New behaviour over the 3-channel part:
- Per-channel tone phase reset on period-high write.
- Single-strobe register bus.
- Optional registered summed mix output.

---
 rtl/psg_multi.sv | 211 +++++++++++++++++++++
 tb/tb_psg_multi.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/psg_multi.sv
// psg_multi: CHANNELS square-wave tone channels, shared 17-bit LFSR noise and 32-step envelope.
// Optional feature macro PSG_MIX_EN builds the registered summed MIX output; otherwise MIX is 0.
module psg_multi #(
  parameter int CHANNELS = 3,
  parameter int TONE_W   = 12,
  parameter int ADDR_W   = $clog2(4*CHANNELS+4)
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            CE,
  input  logic                            WR,
  input  logic [ADDR_W-1:0]               ADDR,
  input  logic [7:0]                      DI,
  output logic [7:0]                      DO,
  output logic [8*CHANNELS-1:0]           CH_OUT,
  output logic [8+$clog2(CHANNELS+1)-1:0] MIX
);
  localparam int G     = 4*CHANNELS;
  localparam int MIX_W = 8+$clog2(CHANNELS+1);
  localparam logic [7:0] LOG_TAB [32] = '{
    8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04,
    8'h06, 8'h07, 8'h09, 8'h0a, 8'h0c, 8'h0e, 8'h11, 8'h13,
    8'h17, 8'h1b, 8'h20, 8'h25, 8'h2c, 8'h35, 8'h3e, 8'h47,
    8'h54, 8'h66, 8'h77, 8'h88, 8'ha1, 8'hc0, 8'he0, 8'hff};

  logic [TONE_W-1:0]   period   [CHANNELS];
  logic [6:0]          ctrl     [CHANNELS];
  logic [4:0]          noise_per;
  logic [15:0]         env_per;
  logic [3:0]          env_shape;
  logic [2:0]          presc;
  logic                half;
  logic [TONE_W-1:0]   tone_cnt [CHANNELS];
  logic [TONE_W-1:0]   tone_lim [CHANNELS];
  logic [CHANNELS-1:0] tone_op;
  logic [4:0]          noise_cnt, noise_lim;
  logic [16:0]         poly;
  logic [15:0]         env_cnt, env_lim;
  logic [4:0]          env_vol;
  logic                env_hold, env_up, env_end;
  logic                tick, ntick;
  logic [CHANNELS-1:0] wr_lo, wr_hi, wr_ctrl, gate;
  logic                wr_np, wr_elo, wr_ehi, wr_shape;
  logic [4:0]          lvl_idx  [CHANNELS];
  logic [7:0]          lvl      [CHANNELS];

  // Bus: WR is a one-cycle write strobe with no ready; every strobe is accepted, every cycle if needed.
  always_comb begin
    wr_lo   = '0;
    wr_hi   = '0;
    wr_ctrl = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      wr_lo[c]   = WR && (ADDR == ADDR_W'(4*c));
      wr_hi[c]   = WR && (ADDR == ADDR_W'(4*c+1));
      wr_ctrl[c] = WR && (ADDR == ADDR_W'(4*c+2));
    end
    wr_np    = WR && (ADDR == ADDR_W'(G));
    wr_elo   = WR && (ADDR == ADDR_W'(G+1));
    wr_ehi   = WR && (ADDR == ADDR_W'(G+2));
    wr_shape = WR && (ADDR == ADDR_W'(G+3));
  end

  always_comb begin
    DO = 8'h00;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ADDR == ADDR_W'(4*c))   DO = period[c][7:0];
      if (ADDR == ADDR_W'(4*c+1)) DO = 8'(period[c][TONE_W-1:8]);
      if (ADDR == ADDR_W'(4*c+2)) DO = {1'b0, ctrl[c]};
    end
    if (ADDR == ADDR_W'(G))   DO = {3'b000, noise_per};
    if (ADDR == ADDR_W'(G+1)) DO = env_per[7:0];
    if (ADDR == ADDR_W'(G+2)) DO = env_per[15:8];
    if (ADDR == ADDR_W'(G+3)) DO = {4'h0, env_shape};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int c = 0; c < CHANNELS; c++) begin
        period[c] <= '0;
        ctrl[c]   <= '0;
      end
      noise_per <= '0;
      env_per   <= '0;
      env_shape <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_lo[c])   period[c][7:0]        <= DI;
        if (wr_hi[c])   period[c][TONE_W-1:8] <= DI[TONE_W-9:0];
        if (wr_ctrl[c]) ctrl[c]               <= DI[6:0];
      end
      if (wr_np)    noise_per     <= DI[4:0];
      if (wr_elo)   env_per[7:0]  <= DI;
      if (wr_ehi)   env_per[15:8] <= DI;
      if (wr_shape) env_shape     <= DI[3:0];
    end
  end

  // Compare limits: a period of 0 behaves like a period of 1.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++)
      tone_lim[c] = (period[c] == '0) ? '0 : period[c] - TONE_W'(1);
    noise_lim = (noise_per == 5'd0) ? 5'd0 : noise_per - 5'd1;
    env_lim   = (env_per == 16'd0) ? 16'd0 : env_per - 16'd1;
    tick      = CE && (presc == 3'd0);
    ntick     = tick && half;
    env_end   = env_up ? (env_vol == 5'd31) : (env_vol == 5'd0);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc     <= '0;
      half      <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) tone_cnt[c] <= '0;
      tone_op   <= '0;
      noise_cnt <= '0;
      poly      <= 17'h00001;
      env_cnt   <= '0;
      env_vol   <= '0;
      env_hold  <= 1'b1;
      env_up    <= 1'b0;
    end else begin
      if (CE) presc <= (presc == 3'd0) ? 3'd7 : presc - 3'd1;
      if (tick) half <= ~half;
      // A period-high write restarts the channel phase and beats any coincident fire.
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_hi[c]) begin
          tone_cnt[c] <= '0;
          tone_op[c]  <= 1'b1;
        end else if (tick) begin
          if (tone_cnt[c] >= tone_lim[c]) begin
            tone_cnt[c] <= '0;
            tone_op[c]  <= ~tone_op[c];
          end else begin
            tone_cnt[c] <= tone_cnt[c] + TONE_W'(1);
          end
        end
      end
      if (ntick) begin
        if (noise_cnt >= noise_lim) begin
          noise_cnt <= '0;
          poly      <= {poly[0] ^ poly[3], poly[16:1]};
        end else begin
          noise_cnt <= noise_cnt + 5'd1;
        end
      end
      if (wr_shape) begin
        env_cnt  <= '0;
        env_hold <= 1'b0;
        env_up   <= DI[2];
        env_vol  <= DI[2] ? 5'd0 : 5'd31;
      end else if (tick) begin
        if (env_cnt >= env_lim) begin
          env_cnt <= '0;
          if (!env_hold) begin
            if (!env_end) begin
              env_vol <= env_up ? env_vol + 5'd1 : env_vol - 5'd1;
            end else if (!env_shape[3]) begin
              env_hold <= 1'b1;
              env_vol  <= 5'd0;
            end else if (env_shape[0]) begin
              env_hold <= 1'b1;
              env_vol  <= (env_shape[2] ^ env_shape[1]) ? 5'd31 : 5'd0;
            end else if (env_shape[1]) begin
              env_up  <= ~env_up;
              env_vol <= env_up ? 5'd30 : 5'd1;
            end else begin
              env_vol <= env_up ? 5'd0 : 5'd31;
            end
          end
        end else begin
          env_cnt <= env_cnt + 16'd1;
        end
      end
    end
  end

  always_comb begin
    gate = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      gate[c]    = (ctrl[c][5] | tone_op[c]) & (ctrl[c][6] | poly[0]);
      lvl_idx[c] = ctrl[c][4] ? env_vol : {ctrl[c][3:0], ctrl[c][3]};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int c = 0; c < CHANNELS; c++) lvl[c] <= 8'h00;
    end else begin
      for (int c = 0; c < CHANNELS; c++) lvl[c] <= gate[c] ? LOG_TAB[lvl_idx[c]] : 8'h00;
    end
  end

  always_comb begin
    CH_OUT = '0;
    for (int c = 0; c < CHANNELS; c++) CH_OUT[8*c +: 8] = lvl[c];
  end

`ifdef PSG_MIX_EN
  logic [MIX_W-1:0] mix_sum;
  always_comb begin
    mix_sum = '0;
    for (int c = 0; c < CHANNELS; c++) mix_sum = mix_sum + MIX_W'(lvl[c]);
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) MIX <= '0;
    else       MIX <= mix_sum;
  end
`else
  assign MIX = '0;
`endif
endmodule

// File: tb/tb_psg_multi.sv
// Directed bench for psg_multi (CHANNELS=3, TONE_W=12): reset, tone, phase reset, envelope, mix, readback.
module tb_psg_multi;
  localparam int ADDR_W = 4;
  localparam int MIX_W  = 10;
  localparam logic [7:0] LOG_TAB [32] = '{
    8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04,
    8'h06, 8'h07, 8'h09, 8'h0a, 8'h0c, 8'h0e, 8'h11, 8'h13,
    8'h17, 8'h1b, 8'h20, 8'h25, 8'h2c, 8'h35, 8'h3e, 8'h47,
    8'h54, 8'h66, 8'h77, 8'h88, 8'ha1, 8'hc0, 8'he0, 8'hff};

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              CE = 1'b0;
  logic              WR = 1'b0;
  logic [ADDR_W-1:0] ADDR = '0;
  logic [7:0]        DI = '0;
  logic [7:0]        DO;
  logic [23:0]       CH_OUT;
  logic [MIX_W-1:0]  MIX;
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  psg_multi #(.CHANNELS(3), .TONE_W(12)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .WR(WR), .ADDR(ADDR),
    .DI(DI), .DO(DO), .CH_OUT(CH_OUT), .MIX(MIX));

  always #5 CLK = ~CLK;

  task automatic clk_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1; CE = 1'b0; WR = 1'b0; ADDR = '0; DI = '0;
    clk_n(2);
    RESET = 1'b0;
    clk_n(1);
  endtask

  task automatic wr_reg(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    WR = 1'b1; ADDR = a; DI = d;
    clk_n(1);
    WR = 1'b0;
  endtask

  function automatic int tri_v(input int s);
    int m;
    m = s % 62;
    return (m <= 31) ? m : 62 - m;
  endfunction

  task automatic test_reset();
    do_reset();
    CE = 1'b1;
    checks++; if (dut.poly !== 17'h00001) begin errors++; $display("FAIL reset_poly: got %h expected 00001", dut.poly); end
    checks++; if (dut.env_vol !== 5'd0) begin errors++; $display("FAIL reset_env: got %0d expected 0", dut.env_vol); end
    for (int a = 0; a < 16; a++) begin
      ADDR = ADDR_W'(a);
      clk_n(1);
      checks++; if (DO !== 8'h00) begin errors++; $display("FAIL reset_do[%0d]: got %h expected 00", a, DO); end
    end
    checks++; if (CH_OUT !== 24'h0) begin errors++; $display("FAIL reset_chout: got %h expected 0", CH_OUT); end
    checks++; if (dut.env_vol !== 5'd0) begin errors++; $display("FAIL reset_env_static: got %0d expected 0", dut.env_vol); end
    checks++; if (MIX !== '0) begin errors++; $display("FAIL reset_mix: got %h expected 0", MIX); end
  endtask

  task automatic test_tone_ch0();
    logic [7:0] exp;
    do_reset();
    wr_reg(4'd0, 8'h01);
    wr_reg(4'd2, 8'h4F);
    CE = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      clk_n(1);
      exp = (k == 1) ? 8'h00 : ((((k - 2) / 8) % 2 == 0) ? 8'hff : 8'h00);
      checks++; if (CH_OUT[7:0] !== exp) begin errors++; $display("FAIL tone0_k%0d: got %h expected %h", k, CH_OUT[7:0], exp); end
    end
    checks++; if (CH_OUT[23:8] !== 16'h0) begin errors++; $display("FAIL tone0_others: got %h expected 0", CH_OUT[23:8]); end
  endtask

  task automatic test_phase_reset();
    do_reset();
    wr_reg(4'd4, 8'h05);
    CE = 1'b1;
    clk_n(32);
    checks++; if (dut.tone_op[1] !== 1'b0) begin errors++; $display("FAIL ch1_p32: got %b expected 0", dut.tone_op[1]); end
    clk_n(1);
    checks++; if (dut.tone_op[1] !== 1'b1) begin errors++; $display("FAIL ch1_p33: got %b expected 1", dut.tone_op[1]); end
    clk_n(39);
    checks++; if (dut.tone_op[1] !== 1'b1) begin errors++; $display("FAIL ch1_p72: got %b expected 1", dut.tone_op[1]); end
    clk_n(1);
    checks++; if (dut.tone_op[1] !== 1'b0) begin errors++; $display("FAIL ch1_p73: got %b expected 0", dut.tone_op[1]); end
    clk_n(17);
    wr_reg(4'd5, 8'h00);
    checks++; if (dut.tone_op[1] !== 1'b1) begin errors++; $display("FAIL ph_mid_op: got %b expected 1", dut.tone_op[1]); end
    checks++; if (dut.tone_cnt[1] !== 12'd0) begin errors++; $display("FAIL ph_mid_cnt: got %0d expected 0", dut.tone_cnt[1]); end
    clk_n(37);
    checks++; if (dut.tone_cnt[1] !== 12'd4) begin errors++; $display("FAIL ph_pre_cnt: got %0d expected 4", dut.tone_cnt[1]); end
    checks++; if (dut.tone_op[1] !== 1'b1) begin errors++; $display("FAIL ph_pre_op: got %b expected 1", dut.tone_op[1]); end
    wr_reg(4'd5, 8'h00);
    checks++; if (dut.tone_op[1] !== 1'b1) begin errors++; $display("FAIL ph_fire_op: got %b expected 1", dut.tone_op[1]); end
    checks++; if (dut.tone_cnt[1] !== 12'd0) begin errors++; $display("FAIL ph_fire_cnt: got %0d expected 0", dut.tone_cnt[1]); end
  endtask

  task automatic test_env_triangle();
    do_reset();
    wr_reg(4'd13, 8'h01);
    wr_reg(4'd2, 8'h70);
    wr_reg(4'd15, 8'h0E);
    checks++; if (dut.env_vol !== 5'd0) begin errors++; $display("FAIL tri_start: got %0d expected 0", dut.env_vol); end
    CE = 1'b1;
    for (int s = 1; s <= 70; s++) begin
      clk_n((s == 1) ? 1 : 8);
      checks++; if (dut.env_vol !== 5'(tri_v(s))) begin errors++; $display("FAIL tri_vol_s%0d: got %0d expected %0d", s, dut.env_vol, tri_v(s)); end
      checks++; if (CH_OUT[7:0] !== LOG_TAB[tri_v(s - 1)]) begin errors++; $display("FAIL tri_chout_s%0d: got %h expected %h", s, CH_OUT[7:0], LOG_TAB[tri_v(s - 1)]); end
    end
  endtask

  task automatic test_env_hold();
    int exp;
    do_reset();
    wr_reg(4'd13, 8'h01);
    wr_reg(4'd2, 8'h70);
    wr_reg(4'd15, 8'h0D);
    CE = 1'b1;
    for (int s = 1; s <= 40; s++) begin
      clk_n((s == 1) ? 1 : 8);
      exp = (s <= 31) ? s : 31;
      checks++; if (dut.env_vol !== 5'(exp)) begin errors++; $display("FAIL hold31_s%0d: got %0d expected %0d", s, dut.env_vol, exp); end
    end
    CE = 1'b0;
    wr_reg(4'd15, 8'h00);
    checks++; if (dut.env_vol !== 5'd31) begin errors++; $display("FAIL shape0_restart: got %0d expected 31", dut.env_vol); end
    CE = 1'b1;
    for (int s = 1; s <= 40; s++) begin
      clk_n(8);
      exp = (s <= 31) ? 31 - s : 0;
      checks++; if (dut.env_vol !== 5'(exp)) begin errors++; $display("FAIL hold0_s%0d: got %0d expected %0d", s, dut.env_vol, exp); end
    end
  endtask

  task automatic test_mix();
    logic [MIX_W-1:0] exp_mix;
`ifdef PSG_MIX_EN
    exp_mix = 10'h2fd;
`else
    exp_mix = 10'h000;
`endif
    do_reset();
    wr_reg(4'd2, 8'h6F);
    wr_reg(4'd6, 8'h6F);
    wr_reg(4'd10, 8'h6F);
    clk_n(2);
    checks++; if (CH_OUT !== 24'hffffff) begin errors++; $display("FAIL mix_chout: got %h expected ffffff", CH_OUT); end
    checks++; if (MIX !== exp_mix) begin errors++; $display("FAIL mix_sum: got %h expected %h", MIX, exp_mix); end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs [8];
    logic [7:0] data [8];
    logic [7:0] exp;
    addrs = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd12, 4'd13, 4'd14, 4'd15};
    data  = '{8'hA5, 8'hFF, 8'hFF, 8'h77, 8'hFF, 8'h3C, 8'hC3, 8'hFF};
    do_reset();
    exp_q = '{8'hA5, 8'h0F, 8'h7F, 8'h00, 8'h1F, 8'h3C, 8'hC3, 8'h0F};
    for (int i = 0; i < 8; i++) wr_reg(addrs[i], data[i]);
    for (int i = 0; i < 8; i++) begin
      ADDR = addrs[i];
      #1;
      exp = exp_q.pop_front();
      checks++; if (DO !== exp) begin errors++; $display("FAIL b2b_read[%0d]: got %h expected %h", addrs[i], DO, exp); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr_reg(4'd0, 8'h01);
    wr_reg(4'd2, 8'h4F);
    CE = 1'b1;
    clk_n(5);
    checks++; if (CH_OUT[7:0] !== 8'hff) begin errors++; $display("FAIL mid_pre_chout: got %h expected ff", CH_OUT[7:0]); end
    RESET = 1'b1;
    #1;
    checks++; if (CH_OUT !== 24'h0) begin errors++; $display("FAIL mid_chout: got %h expected 0", CH_OUT); end
    checks++; if (dut.tone_op !== 3'b000) begin errors++; $display("FAIL mid_op: got %b expected 000", dut.tone_op); end
    checks++; if (dut.poly !== 17'h00001) begin errors++; $display("FAIL mid_poly: got %h expected 00001", dut.poly); end
    ADDR = 4'd2;
    #1;
    checks++; if (DO !== 8'h00) begin errors++; $display("FAIL mid_do: got %h expected 00", DO); end
    clk_n(1);
    RESET = 1'b0;
    checks++; if (dut.tone_op[0] !== 1'b0) begin errors++; $display("FAIL mid_release_op: got %b expected 0", dut.tone_op[0]); end
    clk_n(1);
    checks++; if (dut.tone_op[0] !== 1'b1) begin errors++; $display("FAIL mid_first_tick: got %b expected 1", dut.tone_op[0]); end
  endtask

  initial begin
    test_reset();
    test_tone_ch0();
    test_phase_reset();
    test_env_triangle();
    test_env_hold();
    test_mix();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
